csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_counter.sv | 29 ++
 rtl/csr_unit.sv | 211 +++++++++++++++++++++
 tb/tb_csr_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR address map, access op encodings, interrupt cause codes and
// mstatus/mie bit positions for csr_unit.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // Interrupt cause codes double as their bit index in mie/mip.
  localparam logic [3:0] IRQ_CAUSE_SW    = 4'd3;
  localparam logic [3:0] IRQ_CAUSE_TIMER = 4'd7;
  localparam logic [3:0] IRQ_CAUSE_EXT   = 4'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam int unsigned MIE_MSIE = 3;
  localparam int unsigned MIE_MTIE = 7;
  localparam int unsigned MIE_MEIE = 11;

endpackage

// File: rtl/csr_counter.sv
// 64-bit free-running counter with per-half write ports; a write to either
// half suppresses the increment for that cycle.
module csr_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_en,
  input  logic        wr_lo_en,
  input  logic        wr_hi_en,
  input  logic [31:0] wr_lo_data,
  input  logic [31:0] wr_hi_data,
  output logic [63:0] count
);

  logic [63:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (wr_lo_en || wr_hi_en) begin
      if (wr_lo_en) count_q[31:0]  <= wr_lo_data;
      if (wr_hi_en) count_q[63:32] <= wr_hi_data;
    end else if (inc_en) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap/mret sequencing and interrupt arbitration.
// Optional vectored trap mode is enabled by defining CSR_MTVEC_VECTORED_EN.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] HART_ID   = '0,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            retire_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_epc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] trap_vec_o,
  output logic [XLEN-1:0] mepc_o,
  input  logic            timer_irq_i,
  input  logic            sw_irq_i,
  input  logic            ext_irq_i,
  output logic            irq_req_o,
  output logic [XLEN-1:0] irq_cause_o
);

`ifdef CSR_MTVEC_VECTORED_EN
  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b01};
`else
  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};
`endif
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'(12'h888);

  csr_op_e op;

  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic            mip_sw_q, mip_timer_q, mip_ext_q;
  logic [63:0]     mcycle, minstret;

  logic [XLEN-1:0] mstatus_rd, mip_rd, old_val, new_val, pending;
  logic            implemented, wr_attempt, wr_en;
  logic [63:0]     wval64;
  logic [31:0]     cnt_hi_data;
  logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  assign op = csr_op_e'(csr_op_i);

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
    mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
    mip_rd = '0;
    mip_rd[MIE_MSIE] = mip_sw_q;
    mip_rd[MIE_MTIE] = mip_timer_q;
    mip_rd[MIE_MEIE] = mip_ext_q;
  end

  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS:  old_val = mstatus_rd;
      CSR_MIE:      old_val = mie_q;
      CSR_MIP:      old_val = mip_rd;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MTVAL:    old_val = mtval_q;
      CSR_MHARTID:  old_val = HART_ID;
      CSR_MCYCLE:   old_val = XLEN'(mcycle);
      CSR_MINSTRET: old_val = XLEN'(minstret);
      CSR_MCYCLEH: begin
        if (XLEN == 32) old_val = XLEN'(mcycle >> 32);
        else            implemented = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (XLEN == 32) old_val = XLEN'(minstret >> 32);
        else            implemented = 1'b0;
      end
      default: implemented = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it may target read-only CSRs.
  assign wr_attempt    = (op == CSR_OP_RW) || (csr_wdata_i != '0);
  assign csr_illegal_o = (op != CSR_OP_NONE) &&
                         (!implemented || ((csr_addr_i[11:10] == 2'b11) && wr_attempt));
  assign wr_en         = (op != CSR_OP_NONE) && !csr_illegal_o && wr_attempt;
  assign csr_rdata_o   = (op == CSR_OP_NONE) ? '0 : old_val;

  always_comb begin
    case (op)
      CSR_OP_RW: new_val = csr_wdata_i;
      CSR_OP_RS: new_val = old_val | csr_wdata_i;
      CSR_OP_RC: new_val = old_val & ~csr_wdata_i;
      default:   new_val = old_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RST;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mip_sw_q       <= 1'b0;
      mip_timer_q    <= 1'b0;
      mip_ext_q      <= 1'b0;
    end else begin
      mip_sw_q    <= sw_irq_i;
      mip_timer_q <= timer_irq_i;
      mip_ext_q   <= ext_irq_i;
      if (wr_en) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            if (!trap_i && !mret_i) begin
              mstatus_mie_q  <= new_val[MSTATUS_MIE];
              mstatus_mpie_q <= new_val[MSTATUS_MPIE];
            end
          end
          CSR_MIE:      mie_q      <= new_val & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= new_val & MTVEC_MASK;
          CSR_MSCRATCH: mscratch_q <= new_val;
          CSR_MEPC:     if (!trap_i) mepc_q   <= new_val;
          CSR_MCAUSE:   if (!trap_i) mcause_q <= new_val;
          CSR_MTVAL:    if (!trap_i) mtval_q  <= new_val;
          default: ;
        endcase
      end
      if (trap_i) begin
        mepc_q         <= {trap_epc_i[XLEN-1:2], 2'b00};
        mcause_q       <= trap_cause_i;
        mtval_q        <= trap_tval_i;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
    end
  end

  // Counter halves map onto one 64-bit write for XLEN=64, separate CSRs for XLEN=32.
  assign wval64      = 64'(new_val);
  assign cnt_hi_data = (XLEN == 64) ? wval64[63:32] : wval64[31:0];
  assign cyc_wr_lo   = wr_en && (csr_addr_i == CSR_MCYCLE);
  assign ins_wr_lo   = wr_en && (csr_addr_i == CSR_MINSTRET);
  assign cyc_wr_hi   = wr_en && (csr_addr_i == ((XLEN == 64) ? CSR_MCYCLE : CSR_MCYCLEH));
  assign ins_wr_hi   = wr_en && (csr_addr_i == ((XLEN == 64) ? CSR_MINSTRET : CSR_MINSTRETH));

  csr_counter u_mcycle (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_en     (1'b1),
    .wr_lo_en   (cyc_wr_lo),
    .wr_hi_en   (cyc_wr_hi),
    .wr_lo_data (wval64[31:0]),
    .wr_hi_data (cnt_hi_data),
    .count      (mcycle)
  );

  csr_counter u_minstret (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_en     (retire_i),
    .wr_lo_en   (ins_wr_lo),
    .wr_hi_en   (ins_wr_hi),
    .wr_lo_data (wval64[31:0]),
    .wr_hi_data (cnt_hi_data),
    .count      (minstret)
  );

  assign pending   = mie_q & mip_rd;
  assign irq_req_o = mstatus_mie_q && (pending != '0);

  always_comb begin
    irq_cause_o = '0;
    irq_cause_o[XLEN-1] = 1'b1;
    if (pending[MIE_MEIE])      irq_cause_o[3:0] = IRQ_CAUSE_EXT;
    else if (pending[MIE_MSIE]) irq_cause_o[3:0] = IRQ_CAUSE_SW;
    else if (pending[MIE_MTIE]) irq_cause_o[3:0] = IRQ_CAUSE_TIMER;
    else                        irq_cause_o = '0;
  end

`ifdef CSR_MTVEC_VECTORED_EN
  always_comb begin
    trap_vec_o = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[0] && trap_cause_i[XLEN-1])
      trap_vec_o = {mtvec_q[XLEN-1:2], 2'b00} + {trap_cause_i[XLEN-3:0], 2'b00};
  end
`else
  logic cause_unused;
  assign cause_unused = ^trap_cause_i;
  assign trap_vec_o   = {mtvec_q[XLEN-1:2], 2'b00};
`endif

  assign mepc_o = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: a register-level model checked every cycle
// plus hand-computed literal expectations at key points.
module tb_csr_unit;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] HART = 64'd5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      op;
  logic [11:0]     addr;
  logic [63:0]     wdata, rdata;
  logic            illegal;
  logic            retire, trap, mret;
  logic [63:0]     tcause, tepc, ttval, tvec, mepc;
  logic            tirq, sirq, eirq, irq;
  logic [63:0]     icause;

  int checks   = 0;
  int failures = 0;

  csr_unit #(.XLEN(XLEN), .HART_ID(HART), .MTVEC_RST(64'd0)) dut (
    .clk(clk), .rst_n(rst_n), .csr_op_i(op), .csr_addr_i(addr),
    .csr_wdata_i(wdata), .csr_rdata_o(rdata), .csr_illegal_o(illegal),
    .retire_i(retire), .trap_i(trap), .trap_cause_i(tcause),
    .trap_epc_i(tepc), .trap_tval_i(ttval), .mret_i(mret),
    .trap_vec_o(tvec), .mepc_o(mepc), .timer_irq_i(tirq), .sw_irq_i(sirq),
    .ext_irq_i(eirq), .irq_req_o(irq), .irq_cause_o(icause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
  logic [63:0] m_mcycle, m_minstret, m_mip;
  bit model_ok = 0;

  function automatic bit m_impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_value(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      12'hF14: return HART;
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit m_writes();
    return (op == 2'd1) || (wdata != 64'd0);
  endfunction

  function automatic bit m_illegal();
    if (op == 2'd0) return 1'b0;
    return !m_impl(addr) || ((addr >= 12'hC00) && m_writes());
  endfunction

  function automatic logic [63:0] m_cause();
    logic [63:0] p;
    p = m_mie & m_mip;
    if (p[11]) return 64'h8000_0000_0000_000B;
    if (p[3])  return 64'h8000_0000_0000_0003;
    if (p[7])  return 64'h8000_0000_0000_0007;
    return 64'd0;
  endfunction

  function automatic logic [63:0] m_tvec();
    logic [63:0] base;
    base = m_mtvec & ~64'd3;
`ifdef CSR_MTVEC_VECTORED_EN
    if (m_mtvec[0] && tcause[63]) return base + 4 * (tcause & ~(64'd1 << 63));
`endif
    return base;
  endfunction

  always @(posedge clk) begin
    logic [63:0] old, nv, cyc_n, ins_n, tvmask;
`ifdef CSR_MTVEC_VECTORED_EN
    tvmask = ~64'd2;
`else
    tvmask = ~64'd3;
`endif
    if (!rst_n) begin
      m_mstatus = 64'h1800; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
      m_mtval = 0; m_mscratch = 0; m_mcycle = 0; m_minstret = 0; m_mip = 0;
      model_ok = 1;
    end else begin
      old   = m_value(addr);
      nv    = (op == 2'd1) ? wdata : (op == 2'd2) ? (old | wdata) : (old & ~wdata);
      cyc_n = m_mcycle + 1;
      ins_n = m_minstret + (retire ? 64'd1 : 64'd0);
      if (op != 2'd0 && !m_illegal() && m_writes()) begin
        case (addr)
          12'h300: if (!trap && !mret) m_mstatus = (nv & 64'h88) | 64'h1800;
          12'h304: m_mie = nv & 64'h888;
          12'h305: m_mtvec = nv & tvmask;
          12'h340: m_mscratch = nv;
          12'h341: if (!trap) m_mepc = nv;
          12'h342: if (!trap) m_mcause = nv;
          12'h343: if (!trap) m_mtval = nv;
          12'hB00: cyc_n = nv;
          12'hB02: ins_n = nv;
          default: ;
        endcase
      end
      if (trap) begin
        m_mepc = tepc & ~64'd3; m_mcause = tcause; m_mtval = ttval;
        m_mstatus = 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
      end else if (mret) begin
        m_mstatus = 64'h1880 | (m_mstatus[7] ? 64'h8 : 64'h0);
      end
      m_mcycle = cyc_n; m_minstret = ins_n;
      m_mip = (eirq ? 64'h800 : 64'h0) | (tirq ? 64'h80 : 64'h0) | (sirq ? 64'h8 : 64'h0);
    end
  end

  always @(negedge clk) begin
    if (model_ok && rst_n) begin
      chk("m_rdata",   rdata, (op == 2'd0) ? 64'd0 : m_value(addr));
      chk("m_illegal", {63'd0, illegal}, {63'd0, m_illegal()});
      chk("m_irq_req", {63'd0, irq}, {63'd0, m_mstatus[3] && ((m_mie & m_mip) != 0)});
      chk("m_irq_cause", icause, m_cause());
      chk("m_trap_vec", tvec, m_tvec());
      chk("m_mepc", mepc, m_mepc);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); endtask
  task automatic put(input logic [1:0] o, input logic [11:0] a, input logic [63:0] w);
    op = o; addr = a; wdata = w;
  endtask

  initial begin
    rst_n = 0; put(0, 12'h300, 0); retire = 0; trap = 0; mret = 0;
    tcause = 0; tepc = 0; ttval = 0; tirq = 0; sirq = 0; eirq = 0;
    tick(); tick(); tick();
    rst_n = 1;
    look();
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    chk("rst_mepc", mepc, 64'd0);

    tick(); put(2, 12'h300, 64'h8); look(); chk("rs_old_mstatus", rdata, 64'h1800);
    tick(); put(3, 12'h300, 64'h0); look(); chk("rs_new_mstatus", rdata, 64'h1808);
    tick(); put(2, 12'h300, 64'h0); look(); chk("rc0_no_write", rdata, 64'h1808);
    tick(); put(1, 12'hF14, 64'h7); look(); chk("hartid_wr_illegal", {63'd0, illegal}, 64'd1);
    tick(); put(2, 12'hF14, 64'h0); look();
    chk("hartid_read", rdata, 64'd5);
    chk("hartid_read_legal", {63'd0, illegal}, 64'd0);
    tick(); put(1, 12'h7C0, 64'h1); look(); chk("unimpl_illegal", {63'd0, illegal}, 64'd1);
    tick(); put(1, 12'hB80, 64'h1); look(); chk("mcycleh_rv64_illegal", {63'd0, illegal}, 64'd1);

    tick(); put(1, 12'h304, 64'h880); look();
    tick(); put(0, 12'h000, 0); tirq = 1; eirq = 1; look();
    chk("irq_not_yet", {63'd0, irq}, 64'd0);
    tick(); look();
    chk("irq_req", {63'd0, irq}, 64'd1);
    chk("irq_cause_ext", icause, 64'h8000_0000_0000_000B);
    tick(); eirq = 0; sirq = 1; look();
    tick(); look(); chk("irq_cause_timer", icause, 64'h8000_0000_0000_0007);
    tick(); put(1, 12'h304, 64'h888); look();
    tick(); put(0, 12'h000, 0); look(); chk("irq_cause_sw", icause, 64'h8000_0000_0000_0003);

    tick(); sirq = 0; tirq = 0; put(1, 12'h340, 64'hABCD);
    trap = 1; mret = 1; tepc = 64'h8000_0102; tcause = 64'd2; ttval = 64'h1234; look();
    tick(); trap = 0; mret = 0; put(2, 12'h300, 0); look();
    chk("trap_mepc", mepc, 64'h8000_0100);
    chk("trap_mstatus", rdata, 64'h1880);
    tick(); put(2, 12'h340, 0); look(); chk("trap_side_write", rdata, 64'hABCD);
    tick(); put(2, 12'h342, 0); look(); chk("trap_mcause", rdata, 64'd2);
    tick(); put(3, 12'h300, 64'h80); mret = 1; look();
    tick(); mret = 0; put(2, 12'h300, 0); look(); chk("mret_mstatus", rdata, 64'h1888);

    tick(); put(1, 12'hB00, '1); look();
    tick(); put(2, 12'hB00, 0); look(); chk("mcycle_written", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(); look(); chk("mcycle_wrap", rdata, 64'd0);
    tick(); put(1, 12'hB02, 64'd10); retire = 1; look();
    tick(); put(2, 12'hB02, 0); look(); chk("minstret_wr_prio", rdata, 64'd10);
    tick(); retire = 0; look(); chk("minstret_inc", rdata, 64'd11);

    tick(); put(1, 12'h305, 64'h1001); look();
    tick(); put(2, 12'h305, 0); tcause = 64'h8000_0000_0000_0007; look();
`ifdef CSR_MTVEC_VECTORED_EN
    chk("mtvec_read", rdata, 64'h1001);
    chk("trap_vec_vectored", tvec, 64'h101C);
`else
    chk("mtvec_read", rdata, 64'h1000);
    chk("trap_vec_direct", tvec, 64'h1000);
`endif

    tick(); put(1, 12'h340, 64'h55); trap = 1; tepc = 64'h400; rst_n = 0; look();
    tick(); rst_n = 1; trap = 0; put(2, 12'h340, 0); look();
    chk("rst_drop_write", rdata, 64'd0);
    chk("rst_drop_trap", mepc, 64'd0);
    tick(); put(2, 12'h300, 0); look(); chk("rst_mstatus", rdata, 64'h1800);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
